// File: rtl/led_mon_pkg.sv
// Shared types and default parameters for the LED counter monitor.
// The optional LED check is controlled by LED_MONITOR_LED_CHECK_EN.
package led_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_e;

  localparam int DEF_WIDTH   = 26;
  localparam int DEF_LED_BIT = 25;
  localparam int DEF_ERR_W   = 8;
  localparam int DEF_TOG_W   = 8;

  // Saturation ceiling of the error counter at its default width.
  localparam int ERR_MAX = (1 << DEF_ERR_W) - 1;

endpackage

// File: rtl/led_mon_edge_counter.sv
// Registers the LED pin and counts its edges in a wrapping counter.
// Used only when LED_MONITOR_LED_CHECK_EN is defined.
module led_edge_counter
  import led_mon_pkg::*;
#(
  parameter int TOG_W = DEF_TOG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ena,
  input  logic             i_active,
  input  logic             i_clear,
  input  logic             i_led,
  output logic [TOG_W-1:0] o_toggle_count
);

  localparam logic [TOG_W-1:0] ONE_T = TOG_W'(1);

  logic             r_led;
  logic [TOG_W-1:0] r_toggle_count;
  logic             w_edge;

  // An edge is the cycle in which the registered copy is about to change.
  assign w_edge = (i_led != r_led);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led          <= 1'b0;
      r_toggle_count <= '0;
    end else begin
      r_led <= i_led;
      if (i_clear) begin
        r_toggle_count <= '0;
      end else if (i_ena && i_active && w_edge) begin
        r_toggle_count <= r_toggle_count + ONE_T;
      end
    end
  end

  assign o_toggle_count = r_toggle_count;

endmodule

// File: rtl/led_counter_monitor.sv
// Checks that a free-running counter advances by one per enabled clock and,
// when LED_MONITOR_LED_CHECK_EN is defined, that the LED pin follows its bit.
module led_counter_monitor
  import led_mon_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LED_BIT = DEF_LED_BIT,
  parameter int ERR_W   = DEF_ERR_W,
  parameter int TOG_W   = DEF_TOG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             led_in,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [TOG_W-1:0] toggle_count
);

  localparam logic [WIDTH-1:0] ONE_D = WIDTH'(1);
  localparam logic [ERR_W-1:0] ONE_E = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_SAT =
    (ERR_W == DEF_ERR_W) ? ERR_W'(ERR_MAX) : {ERR_W{1'b1}};

  state_e           r_state;
  logic [WIDTH-1:0] r_expected;
  logic             r_locked;
  logic             r_err;
  logic [ERR_W-1:0] r_err_count;

  logic w_track;
  logic w_cnt_mismatch;
  logic w_led_mismatch;
  logic w_error;
  logic w_sat;

  assign w_track        = ena && (r_state == TRACK);
  assign w_cnt_mismatch = w_track && (data_in != r_expected);
  assign w_sat          = (r_err_count == ERR_SAT);

`ifdef LED_MONITOR_LED_CHECK_EN
  logic [TOG_W-1:0] w_toggle_count;

  assign w_led_mismatch = w_track && (led_in != data_in[LED_BIT]);

  led_edge_counter #(
    .TOG_W (TOG_W)
  ) u_edge_counter (
    .clk            (clk),
    .rst            (rst),
    .i_ena          (ena),
    .i_active       (r_state != IDLE),
    .i_clear        (clear),
    .i_led          (led_in),
    .o_toggle_count (w_toggle_count)
  );

  assign toggle_count = w_toggle_count;
`else
  logic w_unused_led;

  assign w_led_mismatch = 1'b0;
  assign w_unused_led   = ^{led_in, LED_BIT[0]};
  assign toggle_count   = '0;
`endif

  // Counter and LED faults in the same sample are a single error.
  assign w_error = w_cnt_mismatch || w_led_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_expected  <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (!ena) begin
        r_state  <= IDLE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= SYNC;
            r_locked <= 1'b0;
          end
          SYNC: begin
            r_state    <= TRACK;
            r_expected <= data_in + ONE_D;
            r_locked   <= 1'b1;
          end
          TRACK: begin
            r_locked   <= 1'b1;
            // Resync on a bad sample so one glitch costs exactly one error.
            r_expected <= w_cnt_mismatch ? (data_in + ONE_D) : (r_expected + ONE_D);
          end
          default: begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end

      if (w_error) begin
        r_err <= 1'b1;
        if (clear) begin
          r_err_count <= ONE_E;
        end else if (!w_sat) begin
          r_err_count <= r_err_count + ONE_E;
        end
      end else if (clear) begin
        r_err       <= 1'b0;
        r_err_count <= '0;
      end
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_led_counter_monitor.sv
// Directed bench for led_counter_monitor: vector table plus hand sequences.
// Expectations adapt to whether LED_MONITOR_LED_CHECK_EN is defined.
module tb_led_counter_monitor;

`ifdef LED_MONITOR_LED_CHECK_EN
  localparam int LE = 1;
`else
  localparam int LE = 0;
`endif

  typedef struct {
    logic        ena;
    logic        clr;
    logic [25:0] data;
    logic        led;
    logic        lk;
    logic        er;
    logic [7:0]  cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        clear = 1'b0;
  logic [25:0] data_in = '0;
  logic        led_in = 1'b0;
  logic        locked;
  logic        err;
  logic [7:0]  err_count;
  logic [7:0]  toggle_count;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  led_counter_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .clear        (clear),
    .data_in      (data_in),
    .led_in       (led_in),
    .locked       (locked),
    .err          (err),
    .err_count    (err_count),
    .toggle_count (toggle_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic c, input logic [25:0] d, input logic l);
    @(negedge clk);
    ena = e; clear = c; data_in = d; led_in = l;
    @(posedge clk);
    #1;
    $display("[TB] ena=%0b clr=%0b data=%07h led=%0b -> locked=%0b err=%0b cnt=%0d tog=%0d",
             e, c, d, l, locked, err, err_count, toggle_count);
  endtask

  function automatic void add(input logic e, input logic c, input logic [25:0] d, input logic l,
                              input logic lk, input logic er, input logic [7:0] cnt);
    vec_t v;
    v.ena = e; v.clr = c; v.data = d; v.led = l; v.lk = lk; v.er = er; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    int bad;

    // Wrap through all-ones after a fresh resync.
    add(0, 0, 26'h0000000, 0, 0, 0, 8'd0);
    add(1, 0, 26'h3FFFFFC, 1, 0, 0, 8'd0);
    add(1, 0, 26'h3FFFFFD, 1, 1, 0, 8'd0);
    add(1, 0, 26'h3FFFFFE, 1, 1, 0, 8'd0);
    add(1, 0, 26'h3FFFFFF, 1, 1, 0, 8'd0);
    add(1, 0, 26'h0000000, 0, 1, 0, 8'd0);
    add(1, 0, 26'h0000001, 0, 1, 0, 8'd0);
    // Single bad sample, then a clean continuation.
    add(0, 0, 26'h0000000, 0, 0, 0, 8'd0);
    add(1, 0, 26'h00000FE, 0, 0, 0, 8'd0);
    add(1, 0, 26'h00000FF, 0, 1, 0, 8'd0);
    add(1, 0, 26'h0000105, 0, 1, 1, 8'd1);
    add(1, 0, 26'h0000106, 0, 1, 1, 8'd1);
    add(1, 0, 26'h0000107, 0, 1, 1, 8'd1);
    add(1, 0, 26'h0000108, 0, 1, 1, 8'd1);
    add(1, 0, 26'h0000109, 0, 1, 1, 8'd1);
    // Counter glitch plus LED fault together, then LED-only fault.
    add(1, 0, 26'h0000200, 1, 1, 1, 8'd2);
    add(1, 0, 26'h0000201, 0, 1, 1, 8'd2);
    add(1, 0, 26'h0000202, 1, 1, 1, 8'(2 + LE));
    add(1, 0, 26'h0000203, 0, 1, 1, 8'(2 + LE));

    // Reset state
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_toggle", 32'(toggle_count), 0);
    rst = 1'b0;

    // Lock-up and a long clean run
    step(1, 0, 26'd0, 0);
    check("sync_locked", 32'(locked), 0);
    step(1, 0, 26'd1, 0);
    check("lock_at_2", 32'(locked), 1);
    bad = 0;
    for (int i = 2; i < 1002; i++) begin
      @(negedge clk);
      data_in = 26'(i);
      @(posedge clk);
      #1;
      if (err !== 1'b0 || locked !== 1'b1) bad++;
    end
    $display("[TB] clean run of 1000 samples, bad cycles=%0d", bad);
    check("run_bad_cycles", 32'(bad), 0);
    check("run_err_count", 32'(err_count), 0);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ena, vecs[i].clr, vecs[i].data, vecs[i].led);
      check($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].lk));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].er));
      check($sformatf("vec%0d_cnt", i), 32'(err_count), 32'(vecs[i].cnt));
    end

    // Saturation: a frozen counter word mismatches every cycle
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      data_in = 26'h0000500;
      @(posedge clk);
      #1;
      if (i == 9) check("sat_mid_cnt", 32'(err_count), 32'(12 + LE));
    end
    $display("[TB] 300 mismatches -> err=%0b cnt=%0d", err, err_count);
    check("sat_cnt", 32'(err_count), 255);
    check("sat_err", 32'(err), 1);

    // Clear coinciding with an error, then a clean clear
    step(1, 1, 26'h0000500, 0);
    check("clr_err_wins_err", 32'(err), 1);
    check("clr_err_wins_cnt", 32'(err_count), 1);
    step(1, 1, 26'h0000501, 0);
    check("clr_err", 32'(err), 0);
    check("clr_cnt", 32'(err_count), 0);
    step(1, 0, 26'h0000502, 0);
    step(1, 0, 26'h0000503, 0);
    step(1, 0, 26'h0000504, 0);

    // Enable gap with data still counting
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 26'(32'h505 + i), 0);
      check($sformatf("gap%0d_locked", i), 32'(locked), 0);
    end
    step(1, 0, 26'h000050A, 0);
    check("resync_sync_locked", 32'(locked), 0);
    step(1, 0, 26'h000050B, 0);
    check("resync_locked", 32'(locked), 1);
    step(1, 0, 26'h000050C, 0);
    check("resync_err", 32'(err), 0);
    check("resync_cnt", 32'(err_count), 0);

    // LED edge counting (zero when the LED check is compiled out)
    step(1, 1, 26'h000050D, 0);
    check("tog_clear", 32'(toggle_count), 0);
    step(1, 0, 26'h000050E, 1);
    check("tog_rise", 32'(toggle_count), 32'(1 * LE));
    step(1, 0, 26'h000050F, 1);
    check("tog_hold", 32'(toggle_count), 32'(1 * LE));
    step(1, 0, 26'h0000510, 0);
    check("tog_fall", 32'(toggle_count), 32'(2 * LE));
    step(1, 0, 26'h0000511, 1);
    check("tog_rise2", 32'(toggle_count), 32'(3 * LE));
    step(0, 0, 26'h0000512, 0);
    check("tog_disabled", 32'(toggle_count), 32'(3 * LE));
    step(0, 0, 26'h0000513, 1);
    check("tog_idle", 32'(toggle_count), 32'(3 * LE));

    // Reset beats clear and enable
    @(negedge clk);
    rst = 1'b1; ena = 1'b1; clear = 1'b1; data_in = 26'h0000005;
    @(posedge clk);
    #1;
    $display("[TB] rst with ena/clear -> locked=%0b err=%0b cnt=%0d tog=%0d",
             locked, err, err_count, toggle_count);
    check("rst2_locked", 32'(locked), 0);
    check("rst2_err", 32'(err), 0);
    check("rst2_tog", 32'(toggle_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_counter_monitor.md
# led_counter_monitor

Receive-side checker for the LED counter output of the user project. It samples the free-running counter word and the LED pin that the counter drives, and confirms the word advances by exactly one on every enabled clock, including the wrap from all-ones to zero. It also confirms that the LED pin tracks its designated counter bit. It sits beside the user project in the testbench and on-chip debug path, and reports lock, sticky error, saturating error count and LED toggle count.

## Interface
- WIDTH, 26: width of the counter word under check.
- LED_BIT, 25: index of the counter bit that drives the LED pin.
- ERR_W, 8: width of the saturating error counter.
- TOG_W, 8: width of the wrapping LED toggle counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ena  in  1  monitor enable; low forces the IDLE state.
- clear  in  1  one-cycle pulse that clears err, err_count and toggle_count.
- data_in  in  WIDTH  counter word under observation.
- led_in  in  1  LED pin under observation.
- locked  out  1  high while in TRACK.
- err  out  1  sticky error flag.
- err_count  out  ERR_W  error count; saturates at 2^ERR_W-1.
- toggle_count  out  TOG_W  number of LED edges seen; wraps modulo 2^TOG_W.

## Operation
- States:
  - IDLE: entered on reset, or whenever ena=0. The expected value is invalid.
  - SYNC: on the first enabled cycle, capture expected = data_in+1 (mod 2^WIDTH). No comparison this cycle. Next state is TRACK.
  - TRACK: each cycle compare data_in with expected.
    - Match: expected <= expected+1.
    - Mismatch: record an error, then resync with expected <= data_in+1 and stay in TRACK. One error per bad sample; no cascading errors.
- Wrap-around: expected of all-ones followed by data_in of 0 is legal. Arithmetic is modulo 2^WIDTH with no carry out.
- LED check (macro-gated):
  - In TRACK, led_in != data_in[LED_BIT] is an error.
  - A counter mismatch and an LED mismatch in the same cycle count as one error.
- Error recording: err <= 1; err_count increments unless it is already saturated.
- clear: zeroes err, err_count and toggle_count. If clear coincides with an error, the error wins: err=1 and err_count=1.
- ena falling mid-TRACK: next state is IDLE and locked drops. Re-enabling goes through SYNC again, so no error is raised by the gap.
- toggle_count: increments on every change of registered led_in while ena=1, in any state other than IDLE.

## Timing
- Reset values: locked=0, err=0, err_count=0, toggle_count=0, state=IDLE, expected=0, registered led=0.
- Latency:
  - A bad sample at cycle N gives err and err_count updated at N+1.
  - locked rises one cycle after SYNC, i.e. two cycles after ena rises.
- All outputs are registered; there are no combinational paths from input to output.
- rst has priority over clear and ena.

## Configuration
- LED_MONITOR_LED_CHECK_EN:
  - Defined: the LED comparison and the toggle counter are compiled in.
  - Undefined: led_in is ignored, toggle_count is tied to 0, and only the counter sequence is checked.

## Structure
- Package led_mon_pkg:
  - state enum: IDLE, SYNC, TRACK.
  - Default WIDTH, LED_BIT, ERR_W and TOG_W constants.
  - Saturation helper constant ERR_MAX.
- One sub-module, led_edge_counter: registers led_in, detects edges and holds the wrapping toggle count, with clear. It is instantiated only under LED_MONITOR_LED_CHECK_EN.

## Test plan
- Reset, then ena=1 with data_in incrementing from 0 and led_in=data_in[25] -> locked=1 at cycle 2; err=0 throughout 1000 cycles.
- data_in runs 0x3FFFFFE, 0x3FFFFFF, 0x0000000, 0x0000001 -> no error; wrap is accepted.
- Inject data_in=0x0000105 where 0x0000100 is expected, then continue incrementing from 0x0000106 -> err=1 and err_count=1 one cycle later; no further errors.
- Force an LED mismatch together with a counter glitch in the same cycle -> err_count increments by exactly 1. With the macro undefined, an LED-only mismatch gives no error.
- Inject 300 consecutive mismatches -> err_count holds at 255. Pulse clear in the same cycle as a new error -> err=1 and err_count=1.
- Drop ena for 5 cycles while data_in keeps counting, then re-raise it -> locked is low during the gap, the monitor resyncs, and there is no error.
